// File: rtl/core_pkg.sv
// core_pkg: shared widths, entry layout and constants for the front-end queue.
// Ports: none (package only).
// Provides INST_W, PC_W, IQ_DEPTH, iq_entry_t and INST_NOP.
package core_pkg;

  localparam int INST_W   = 32;
  localparam int PC_W     = 32;
  localparam int IQ_DEPTH = 8;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } iq_entry_t;

  localparam logic [INST_W-1:0] INST_NOP = 32'h0;

endpackage

// File: rtl/inst_queue_if.sv
// inst_queue_if: fetch/issue side bundle of the dual-issue instruction queue.
// Ports: flush, push_cnt/push_inst1/push_inst2/push_pc/push_ready (fetch side),
//        issue_cnt, inst_en, out_inst1/2, out_pc1/2, out_valid (decode side).
interface inst_queue_if;
  import core_pkg::*;

  logic              flush;
  logic [1:0]        push_cnt;
  logic [INST_W-1:0] push_inst1;
  logic [INST_W-1:0] push_inst2;
  logic [PC_W-1:0]   push_pc;
  logic              push_ready;
  logic              inst_en;
  logic [INST_W-1:0] out_inst1;
  logic [INST_W-1:0] out_inst2;
  logic [PC_W-1:0]   out_pc1;
  logic [PC_W-1:0]   out_pc2;
  logic [1:0]        out_valid;
  logic [1:0]        issue_cnt;

  // master: fetch/issue logic driving the queue
  modport master (
    output flush, push_cnt, push_inst1, push_inst2, push_pc, issue_cnt,
    input  push_ready, inst_en, out_inst1, out_inst2, out_pc1, out_pc2, out_valid
  );

  // slave: the queue itself
  modport slave (
    input  flush, push_cnt, push_inst1, push_inst2, push_pc, issue_cnt,
    output push_ready, inst_en, out_inst1, out_inst2, out_pc1, out_pc2, out_valid
  );

endinterface

// File: rtl/inst_queue.sv
// inst_queue: dual-issue circular instruction queue between fetch and decode.
// Ports: clk, rst (sync, active-high), iq (inst_queue_if.slave: push, issue, pair outputs).
// Latency 1 cycle push-to-visible, no empty bypass; push_ready drops when fewer than 2 entries free.
module inst_queue
  import core_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  inst_queue_if.slave  iq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  iq_entry_t       mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;

  logic [AW-1:0]   head_p1;
  logic [AW-1:0]   tail_p1;
  logic [1:0]      push_req;
  logic [1:0]      issue_req;
  logic [1:0]      push_n;
  logic [1:0]      pop_n;
  logic            ready;

  assign head_p1 = head + AW'(1);
  assign tail_p1 = tail + AW'(1);

  // Readiness uses the pre-pop count so a 2-word push can never overflow.
  assign ready = (count <= CW'(DEPTH - 2));

  always_comb begin
    push_req  = (iq.push_cnt == 2'd3) ? 2'd2 : iq.push_cnt;
    issue_req = (iq.issue_cnt == 2'd3) ? 2'd2 : iq.issue_cnt;
    push_n    = 2'd0;
    if (!rst && !iq.flush && ready)
      push_n = push_req;
    // Pop is clipped to what is actually held; excess requests are ignored.
    pop_n = issue_req;
    if (CW'(issue_req) > count)
      pop_n = count[1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || iq.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop_n);
      tail  <= tail + AW'(push_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  // Storage is not reset; the valid bits mask stale contents.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0)
      mem[tail] <= '{inst: iq.push_inst1, pc: iq.push_pc};
    if (push_n == 2'd2)
      mem[tail_p1] <= '{inst: iq.push_inst2, pc: iq.push_pc + PC_W'(4)};
  end

  logic [1:0] vld;
  assign vld = {count >= CW'(2), count >= CW'(1)};

  assign iq.push_ready = ready;
  assign iq.out_valid  = vld;
  assign iq.inst_en    = vld[0];
  assign iq.out_inst1  = vld[0] ? mem[head].inst    : INST_NOP;
  assign iq.out_pc1    = vld[0] ? mem[head].pc      : '0;
  assign iq.out_inst2  = vld[1] ? mem[head_p1].inst : INST_NOP;
  assign iq.out_pc2    = vld[1] ? mem[head_p1].pc   : '0;

endmodule
